// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: source index map, default widths and index-width helpers.
// Imported by the bus multiplexer and the control unit.
package cpu_bus_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_N_SRC  = 24;

    localparam int SRC_R0     = 0;
    localparam int SRC_R1     = 1;
    localparam int SRC_R2     = 2;
    localparam int SRC_R3     = 3;
    localparam int SRC_R4     = 4;
    localparam int SRC_R5     = 5;
    localparam int SRC_R6     = 6;
    localparam int SRC_R7     = 7;
    localparam int SRC_R8     = 8;
    localparam int SRC_R9     = 9;
    localparam int SRC_R10    = 10;
    localparam int SRC_R11    = 11;
    localparam int SRC_R12    = 12;
    localparam int SRC_R13    = 13;
    localparam int SRC_R14    = 14;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_CSIGN  = 23;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // An index port is never narrower than one bit, even for a single source.
    function automatic int idxWidth(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// Fixed-priority encoder for strobe vectors: lowest set bit wins.
// Also flags "any strobe" and "two or more strobes"; purely combinational.
module onehot_prio_enc
    import cpu_bus_pkg::*;
#(
    parameter int N = DEFAULT_N_SRC,
    localparam int IDX_W = idxWidth(N)
) (
    input  logic [N-1:0]     strobes,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    logic found;

    // NOTE: every output of this block gets a default before the loop, so no path
    // through it leaves a value unassigned and no latch is inferred.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (strobes[i]) begin
                if (found) begin
                    multi = 1'b1;
                end else begin
                    idx   = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end
        any = found;
    end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered CPU bus multiplexer: encodes one-hot source strobes, drives the bus
// (optionally holding the last value) and tracks multi-driver conflicts.
module bus_mux_reg
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int N_SRC     = DEFAULT_N_SRC,
    parameter int CNT_W     = 8,
    parameter int REG_OUT   = 1,
    parameter int HOLD_LAST = 1,
    localparam int SEL_W    = idxWidth(N_SRC)
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_out,
    input  logic                    conflict_clr,
    output logic [DATA_W-1:0]       bus_out,
    output logic                    bus_valid,
    output logic [SEL_W-1:0]        sel_idx,
    output logic                    conflict,
    output logic                    conflict_sticky,
    output logic [CNT_W-1:0]        conflict_count
);

    logic [SEL_W-1:0]  winIdx;
    logic              anyActive;
    logic              multiActive;
    logic [DATA_W-1:0] winData;
    logic [DATA_W-1:0] holdVal;
    logic [DATA_W-1:0] nextBus;

    onehot_prio_enc #(.N(N_SRC)) uEnc (
        .strobes (src_out),
        .idx     (winIdx),
        .any     (anyActive),
        .multi   (multiActive)
    );

    always_comb begin
        winData = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (winIdx == SEL_W'(i)) begin
                winData = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    generate
        if (HOLD_LAST != 0) begin : gHold
            logic [DATA_W-1:0] holdReg;
            // NOTE: state is updated with non-blocking assignments so every register
            // samples pre-edge values regardless of block ordering.
            always_ff @(posedge clock) begin
                if (clear) begin
                    holdReg <= '0;
                end else if (anyActive) begin
                    holdReg <= winData;
                end
            end
            assign holdVal = holdReg;
        end else begin : gNoHold
            assign holdVal = '0;
        end
    endgenerate

    assign nextBus = anyActive ? winData : holdVal;

    generate
        if (REG_OUT != 0) begin : gRegOut
            logic [DATA_W-1:0] busReg;
            logic              validReg;
            always_ff @(posedge clock) begin
                if (clear) begin
                    busReg   <= '0;
                    validReg <= 1'b0;
                end else begin
                    busReg   <= nextBus;
                    validReg <= anyActive;
                end
            end
            assign bus_out   = busReg;
            assign bus_valid = validReg;
        end else begin : gCombOut
            assign bus_out   = nextBus;
            assign bus_valid = anyActive;
        end
    endgenerate

    // Status is registered in both output modes; a simultaneous conflict beats conflict_clr.
    always_ff @(posedge clock) begin
        if (clear) begin
            sel_idx         <= '0;
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            conflict_count  <= '0;
        end else begin
            if (anyActive) begin
                sel_idx <= winIdx;
            end
            conflict <= multiActive;
            if (multiActive) begin
                conflict_sticky <= 1'b1;
                if (conflict_clr) begin
                    conflict_count <= CNT_W'(1);
                end else if (conflict_count != {CNT_W{1'b1}}) begin
                    conflict_count <= conflict_count + CNT_W'(1);
                end
            end else if (conflict_clr) begin
                conflict_sticky <= 1'b0;
                conflict_count  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_mux_reg.sv
// Self-checking bench for bus_mux_reg: three parameter variants share one stimulus
// stream and are compared against a behavioural model of the bus rules.
module tb_bus_mux_reg;
    import cpu_bus_pkg::*;

    localparam int DW = 32;
    localparam int NS = 24;
    localparam int SW = 5;

    logic              clock = 1'b0;
    logic              clear;
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_out;
    logic              conflict_clr;

    // A: registered, hold-last, 8-bit counter
    logic [DW-1:0] aBus;  logic aValid; logic [SW-1:0] aSel; logic aConf; logic aSticky; logic [7:0] aCount;
    // B: registered, zero-fill, 4-bit counter
    logic [DW-1:0] bBus;  logic bValid; logic [SW-1:0] bSel; logic bConf; logic bSticky; logic [3:0] bCount;
    // C: combinational bus, hold-last, 8-bit counter
    logic [DW-1:0] cBus;  logic cValid; logic [SW-1:0] cSel; logic cConf; logic cSticky; logic [7:0] cCount;

    always #5 clock = ~clock;

    bus_mux_reg #(.DATA_W(DW), .N_SRC(NS), .CNT_W(8), .REG_OUT(1), .HOLD_LAST(1)) dutA (
        .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
        .conflict_clr(conflict_clr), .bus_out(aBus), .bus_valid(aValid), .sel_idx(aSel),
        .conflict(aConf), .conflict_sticky(aSticky), .conflict_count(aCount));

    bus_mux_reg #(.DATA_W(DW), .N_SRC(NS), .CNT_W(4), .REG_OUT(1), .HOLD_LAST(0)) dutB (
        .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
        .conflict_clr(conflict_clr), .bus_out(bBus), .bus_valid(bValid), .sel_idx(bSel),
        .conflict(bConf), .conflict_sticky(bSticky), .conflict_count(bCount));

    bus_mux_reg #(.DATA_W(DW), .N_SRC(NS), .CNT_W(8), .REG_OUT(0), .HOLD_LAST(1)) dutC (
        .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
        .conflict_clr(conflict_clr), .bus_out(cBus), .bus_valid(cValid), .sel_idx(cSel),
        .conflict(cConf), .conflict_sticky(cSticky), .conflict_count(cCount));

    // Reference model state, one entry per variant (A, B, C).
    int          cntMax   [3] = '{255, 15, 255};
    bit          holdLast [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] mBus     [3];
    logic [31:0] mHold    [3];
    logic        mValid   [3];
    logic [4:0]  mSel     [3];
    logic        mConf    [3];
    logic        mSticky  [3];
    int          mCount   [3];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    localparam logic [NS-1:0] CONFLICT_3_16 = (24'd1 << 3) | (24'd1 << 16);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sliceOf(input int i);
        return src_data[i*DW +: DW];
    endfunction

    function automatic int lowestSet(input logic [NS-1:0] s);
        for (int i = 0; i < NS; i++) begin
            if (s[i]) return i;
        end
        return 0;
    endfunction

    task automatic setSrc(input int i, input logic [31:0] v);
        src_data[i*DW +: DW] = v;
    endtask

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            mBus[k] = '0; mHold[k] = '0; mValid[k] = 1'b0; mSel[k] = '0;
            mConf[k] = 1'b0; mSticky[k] = 1'b0; mCount[k] = 0;
        end
    endtask

    // One clock edge of the bus rules, applied to the inputs currently driven.
    task automatic modelEdge();
        int nAct;
        int win;
        nAct = $countones(src_out);
        win  = lowestSet(src_out);
        if (clear) begin
            modelReset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (nAct > 0) begin
                mBus[k]   = sliceOf(win);
                mValid[k] = 1'b1;
                mSel[k]   = 5'(win);
                mHold[k]  = sliceOf(win);
            end else begin
                mBus[k]   = holdLast[k] ? mHold[k] : 32'h0;
                mValid[k] = 1'b0;
            end
            mConf[k] = (nAct >= 2);
            if (nAct >= 2) begin
                mSticky[k] = 1'b1;
                mCount[k]  = conflict_clr ? 1 : ((mCount[k] < cntMax[k]) ? mCount[k] + 1 : mCount[k]);
            end else if (conflict_clr) begin
                mSticky[k] = 1'b0;
                mCount[k]  = 0;
            end
        end
    endtask

    task automatic checkAll();
        check("A.bus",     aBus,          mBus[0]);
        check("A.valid",   32'(aValid),   32'(mValid[0]));
        check("A.sel",     32'(aSel),     32'(mSel[0]));
        check("A.conf",    32'(aConf),    32'(mConf[0]));
        check("A.sticky",  32'(aSticky),  32'(mSticky[0]));
        check("A.count",   32'(aCount),   mCount[0]);
        check("B.bus",     bBus,          mBus[1]);
        check("B.valid",   32'(bValid),   32'(mValid[1]));
        check("B.sel",     32'(bSel),     32'(mSel[1]));
        check("B.conf",    32'(bConf),    32'(mConf[1]));
        check("B.sticky",  32'(bSticky),  32'(mSticky[1]));
        check("B.count",   32'(bCount),   mCount[1]);
        check("C.sel",     32'(cSel),     32'(mSel[2]));
        check("C.conf",    32'(cConf),    32'(mConf[2]));
        check("C.sticky",  32'(cSticky),  32'(mSticky[2]));
        check("C.count",   32'(cCount),   mCount[2]);
    endtask

    // Drive on the falling edge, check the combinational variant mid-cycle,
    // advance the model on the rising edge and check registered outputs just after it.
    task automatic step(input logic clr, input logic [NS-1:0] strb, input logic cclr);
        logic [31:0] combExp;
        @(negedge clock);
        clear        = clr;
        src_out      = strb;
        conflict_clr = cclr;
        #1;
        if (!clr) begin
            combExp = (strb != '0) ? sliceOf(lowestSet(strb)) : mHold[2];
            check("C.bus_comb",   cBus,         combExp);
            check("C.valid_comb", 32'(cValid),  32'(strb != '0));
        end
        @(posedge clock);
        modelEdge();
        #1;
        checkAll();
    endtask

    initial begin
        logic [NS-1:0] strb;
        clear        = 1'b1;
        src_out      = '0;
        conflict_clr = 1'b0;
        src_data     = '0;
        modelReset();

        // Reset, then a single PC source
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        check("rst.bus", aBus, 32'h0);
        check("rst.count", 32'(aCount), 32'h0);
        setSrc(SRC_PC, 32'h0000_0100);
        step(1'b0, 24'd1 << SRC_PC, 1'b0);
        check("pc.bus", aBus, 32'h0000_0100);
        check("pc.sel", 32'(aSel), 32'd20);
        check("pc.valid", 32'(aValid), 32'd1);

        // Hold behaviour
        setSrc(SRC_MDR, 32'hDEAD_BEEF);
        step(1'b0, 24'd1 << SRC_MDR, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0);
            check("hold.A.bus", aBus, 32'hDEAD_BEEF);
            check("hold.A.valid", 32'(aValid), 32'd0);
            check("hold.B.bus", bBus, 32'h0);
        end

        // Conflict priority
        setSrc(SRC_R3, 32'h11);
        setSrc(SRC_HI, 32'h22);
        step(1'b0, CONFLICT_3_16, 1'b0);
        check("prio.bus", aBus, 32'h11);
        check("prio.sel", 32'(aSel), 32'd3);
        check("prio.conf", 32'(aConf), 32'd1);
        check("prio.count", 32'(aCount), 32'd1);
        step(1'b0, '0, 1'b0);
        check("prio.pulse_end", 32'(aConf), 32'd0);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) step(1'b0, CONFLICT_3_16, 1'b0);
        check("sat.B.count", 32'(bCount), 32'd15);
        check("sat.A.count", 32'(aCount), 32'd21);

        // Clear vs. set, then clear alone
        step(1'b0, CONFLICT_3_16, 1'b1);
        check("clrset.count", 32'(aCount), 32'd1);
        check("clrset.sticky", 32'(aSticky), 32'd1);
        step(1'b0, '0, 1'b1);
        check("clr.count", 32'(aCount), 32'd0);
        check("clr.sticky", 32'(aSticky), 32'd0);

        // Reset in the same cycle as a transaction
        setSrc(SRC_R5, 32'h55);
        step(1'b1, 24'd1 << SRC_R5, 1'b0);
        check("midrst.bus", aBus, 32'h0);
        check("midrst.valid", 32'(aValid), 32'd0);

        // Combinational variant follows in the same cycle
        setSrc(SRC_R7, 32'h77);
        step(1'b0, 24'd1 << SRC_R7, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NS; i++) setSrc(i, $urandom());
            case ($urandom_range(0, 3))
                0:       strb = '0;
                1:       strb = 24'd1 << $urandom_range(0, NS - 1);
                default: strb = (24'd1 << $urandom_range(0, NS - 1)) | (24'd1 << $urandom_range(0, NS - 1))
                              | ((24'd1 << $urandom_range(0, NS - 1)) & {NS{$urandom_range(0, 1) == 1}});
            endcase
            step($urandom_range(0, 29) == 0, strb, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised, registered datapath bus multiplexer for the CPU.
- Takes one-hot "out" strobes from the control unit (R0out..Cout) instead of a pre-encoded select, and encodes them internally.
- Drives the shared bus through an output register, with optional last-value hold.
- Detects multi-driver conflicts and counts them, for debug and for the verification bench.

Parameters:
- DATA_W, 32, bus width in bits.
- N_SRC, 24, number of bus sources; strobe bit i selects slice i.
- CNT_W, 8, width of the saturating conflict counter.
- REG_OUT, 1, 1 = bus_out registered (1-cycle latency); 0 = bus_out combinational; status outputs are registered in both modes.
- HOLD_LAST, 1, 1 = bus holds last driven value when no strobe is active; 0 = bus reads zero.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  synchronous active-high reset.
- src_data  in  N_SRC*DATA_W  flattened sources; source i occupies bits [i*DATA_W +: DATA_W].
- src_out  in  N_SRC  one-hot source strobes from the control unit.
- conflict_clr  in  1  clears conflict_sticky and conflict_count.
- bus_out  out  DATA_W  bus value.
- bus_valid  out  1  bus_out carries a value driven this transaction (not held, not zero-filled).
- sel_idx  out  clog2(N_SRC)  index of the winning source.
- conflict  out  1  one-cycle pulse: two or more strobes were active.
- conflict_sticky  out  1  latched conflict indicator.
- conflict_count  out  CNT_W  saturating count of conflict cycles.

Behaviour:
- clock is the only clock. clear is synchronous and active-high, and is sampled on the rising edge of clock.
- Reset values on clear:
  - bus_out = 0, bus_valid = 0, sel_idx = 0.
  - conflict = 0, conflict_sticky = 0, conflict_count = 0.
  - The internal hold register = 0.
- clear takes priority over every other input in the same cycle. A clear asserted mid-transaction discards that transaction: no valid output and no conflict is recorded for it.
- Encoding:
  - The lowest-index active strobe wins; this is a fixed priority.
  - any = OR of src_out.
  - multi = 1 when two or more bits of src_out are set.
- REG_OUT=1: at edge t+1 after strobes are presented at t:
  - any=1: bus_out <= winning slice, bus_valid <= 1, sel_idx <= winner.
  - any=0: bus_out <= hold register (HOLD_LAST=1) or 0 (HOLD_LAST=0), bus_valid <= 0, sel_idx unchanged.
- REG_OUT=0:
  - bus_out follows the same selection combinationally in the same cycle.
  - bus_valid = any, combinationally.
  - sel_idx is still registered.
- Hold register loads the winning slice on every cycle with any=1.
- Conflict handling:
  - conflict <= multi; it is high for exactly one cycle per conflicting cycle.
  - conflict_sticky <= 1 on multi.
  - conflict_count increments by 1 on multi and saturates at 2^CNT_W-1 with no wrap.
- conflict_clr:
  - zeroes conflict_sticky and conflict_count on the next edge.
  - When conflict_clr and multi occur in the same cycle, set wins: sticky = 1, count = 1.
  - conflict_clr does not affect the conflict pulse or bus_out.
- Strobes beyond N_SRC do not exist; src_data contents are don't-care while the corresponding strobe is low.
- Width rule: sel_idx width = max(1, clog2(N_SRC)).

Decomposition:
- Shared package cpu_bus_pkg holds:
  - The clog2 function.
  - Source index constants: SRC_R0..SRC_R15 = 0..15, SRC_HI = 16, SRC_LO = 17, SRC_ZHI = 18, SRC_ZLO = 19, SRC_PC = 20, SRC_MDR = 21, SRC_INPORT = 22, SRC_CSIGN = 23.
  - The default DATA_W.
- One sub-module: onehot_prio_enc, parametrised on N. It outputs idx, any and multi; it is purely combinational and is reused by the control unit.

Test Plan:
- Reset and single source:
  - Stimulus: clear=1 for 2 cycles, then src_out bit 20 (PC) high with PC slice = 0x0000_0100.
  - Response: every output is 0 during reset; next edge gives bus_out = 0x0000_0100, bus_valid = 1, sel_idx = 20, conflict = 0.
- Hold behaviour:
  - Stimulus: drive MDR = 0xDEAD_BEEF for 1 cycle, then no strobes for 3 cycles.
  - Response with HOLD_LAST=1: bus_out stays 0xDEAD_BEEF and bus_valid = 0 for the 3 cycles.
  - Response with HOLD_LAST=0: bus_out = 0 for the 3 cycles.
- Conflict priority:
  - Stimulus: strobes 3 and 16 high together, with R3 = 0x11 and HI = 0x22.
  - Response: bus_out = 0x11, sel_idx = 3, conflict pulse for 1 cycle, conflict_sticky = 1, conflict_count = 1.
- Saturation:
  - Stimulus: CNT_W=4, 20 consecutive conflict cycles.
  - Response: conflict_count stops at 15, conflict_sticky = 1.
- Clear vs. set:
  - Stimulus: conflict_clr together with a new conflict.
  - Response: conflict_count = 1, conflict_sticky = 1.
  - Follow-up: conflict_clr alone gives conflict_count = 0, conflict_sticky = 0.
- Reset mid-operation and REG_OUT=0:
  - Stimulus: clear asserted in the same cycle as strobe 5 with R5 = 0x55.
  - Response: all outputs 0 next cycle.
  - Stimulus: REG_OUT=0 with strobe 7 and R7 = 0x77.
  - Response: bus_out = 0x77 in the same cycle.
